// File: rtl/hazard_track_unit_pkg.sv
// Shared layout for the hazard tracker: entry field positions, entry width, stall_run saturation.
// Flags sit in the low bits so their positions do not depend on REG_W.
package hazard_track_unit_pkg;

  localparam int REG_W_DEF = 4;

  localparam int ENT_V    = 0;
  localparam int ENT_WB   = 1;
  localparam int ENT_LD   = 2;
  localparam int ENT_DEST = 3;

  localparam int ENT_W_DEF = ENT_DEST + REG_W_DEF;

  localparam logic [3:0] STALL_SAT = 4'd15;

  function automatic int ent_w(input int reg_w);
    return ENT_DEST + reg_w;
  endfunction

endpackage

// File: rtl/hazard_track_pipe.sv
// DEPTH-entry shift register of in-flight writers after ID; entry 0 = EXE.
// One entry per clock, no backpressure: a bubble is loaded whenever load is low.
module hazard_track_pipe
  import hazard_track_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int DEPTH = 2,
  parameter int EW    = ent_w(REG_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [EW-1:0]         load_ent,
  output logic [DEPTH*EW-1:0]   ents
);

  logic [EW-1:0] ent_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      ent_q[0] <= load ? load_ent : '0;
      for (int i = 1; i < DEPTH; i++) ent_q[i] <= ent_q[i-1];
    end
  end

  always_comb begin
    ents = '0;
    for (int i = 0; i < DEPTH; i++) ents[i*EW +: EW] = ent_q[i];
  end

endmodule

// File: rtl/hazard_track_unit.sv
// ID-stage hazard detector with an internal writer tracker; hazard is combinational, stats registered.
// Holds PC and IF/ID while hazard=1; optional stall counter under HAZARD_PERF_CNT_EN.
module hazard_track_unit
  import hazard_track_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             two_src,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             fwd_en,
  output logic             hazard,
  output logic [3:0]       stall_run,
  output logic             deadlock_err,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam int EW = ent_w(REG_W);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [DEPTH*EW-1:0] ents;
  logic [EW-1:0]       id_ent;
  logic                issue;
  logic [EW-1:0]       ent;
  logic                hit;
  logic                any_hit;
  logic                ld_use;

  assign issue = id_valid & ~hazard & ~flush;

  always_comb begin
    id_ent                        = '0;
    id_ent[ENT_V]                 = 1'b1;
    id_ent[ENT_WB]                = id_wb_en;
    id_ent[ENT_LD]                = id_mem_read;
    id_ent[ENT_DEST +: REG_W]     = id_dest;
  end

  hazard_track_pipe #(
    .REG_W (REG_W),
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .load_ent (id_ent),
    .ents     (ents)
  );

  // Load-use only looks at EXE; everything deeper is reachable by forwarding.
  always_comb begin
    ent     = '0;
    hit     = 1'b0;
    any_hit = 1'b0;
    ld_use  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent = ents[i*EW +: EW];
      hit = ent[ENT_V] & ent[ENT_WB] &
            ((ent[ENT_DEST +: REG_W] == src1) |
             (two_src & (ent[ENT_DEST +: REG_W] == src2)));
      if (hit) begin
        any_hit = 1'b1;
        if (i == 0 && ent[ENT_LD]) ld_use = 1'b1;
      end
    end
    hazard = id_valid & ~flush & (fwd_en ? ld_use : any_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_run    <= '0;
      deadlock_err <= 1'b0;
    end else begin
      if (hazard) begin
        if (stall_run != STALL_SAT) stall_run <= stall_run + 4'd1;
        if ({1'b0, stall_run} > DEPTH_L) deadlock_err <= 1'b1;
      end else begin
        stall_run <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         perf_stall_cnt <= '0;
    else if (hazard) perf_stall_cnt <= perf_stall_cnt + 1'b1;
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// Directed bench for hazard_track_unit with a queue-based reference model checked every cycle.
module tb_hazard_track_unit;

  localparam int DEPTH = 2;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, two_src, id_wb_en, id_mem_read, flush, fwd_en;
  logic [REG_W-1:0] src1, src2, id_dest;
  logic             hazard, deadlock_err;
  logic [3:0]       stall_run;
  logic [CNT_W-1:0] perf_stall_cnt;

  hazard_track_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .two_src        (two_src),
    .src1           (src1),
    .src2           (src2),
    .id_dest        (id_dest),
    .id_wb_en       (id_wb_en),
    .id_mem_read    (id_mem_read),
    .flush          (flush),
    .fwd_en         (fwd_en),
    .hazard         (hazard),
    .stall_run      (stall_run),
    .deadlock_err   (deadlock_err),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of the last DEPTH cycles' issued writers, newest first.
  typedef struct {
    bit wb;
    bit ld;
    int dest;
  } ins_t;

  ins_t hist[$];
  int   m_run  = 0;
  bit   m_dead = 1'b0;
  int   m_perf = 0;

  function automatic bit m_hazard();
    if (!id_valid || flush) return 1'b0;
    for (int i = 0; i < hist.size(); i++) begin
      bit reads;
      reads = (hist[i].dest == int'(src1)) || (two_src && hist[i].dest == int'(src2));
      if (hist[i].wb && reads && (!fwd_en || (i == 0 && hist[i].ld))) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_run  = 0;
      m_dead = 1'b0;
      m_perf = 0;
    end else begin
      bit   h;
      ins_t e;
      h = m_hazard();
      if (h && m_run > DEPTH) m_dead = 1'b1;
      m_run = h ? ((m_run < 15) ? m_run + 1 : 15) : 0;
      if (h) m_perf++;
      e.wb   = id_valid && !flush && !h && id_wb_en;
      e.ld   = id_mem_read;
      e.dest = int'(id_dest);
      hist.push_front(e);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_hazard", hazard, m_hazard());
      chk("m_stall_run", stall_run, m_run);
      chk("m_deadlock", deadlock_err, m_dead);
`ifdef HAZARD_PERF_CNT_EN
      chk("m_perf", perf_stall_cnt, m_perf % (1 << CNT_W));
`else
      chk("m_perf", perf_stall_cnt, 0);
`endif
    end
  end

  task automatic drv(input bit v, input bit two, input int s1, input int s2, input int d,
                     input bit wb, input bit ld, input bit fl, input bit fw);
    @(posedge clk);
    #1;
    id_valid    = v;
    two_src     = two;
    src1        = REG_W'(s1);
    src2        = REG_W'(s2);
    id_dest     = REG_W'(d);
    id_wb_en    = wb;
    id_mem_read = ld;
    flush       = fl;
    fwd_en      = fw;
  endtask

  task automatic idle(input bit fw);
    drv(0, 0, 0, 0, 0, 0, 0, 0, fw);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; two_src = 0; src1 = 0; src2 = 0; id_dest = 0;
    id_wb_en = 0; id_mem_read = 0; flush = 0; fwd_en = 0;
    #2;
    chk("reset hazard", hazard, 0);
    chk("reset stall_run", stall_run, 0);
    chk("reset deadlock", deadlock_err, 0);
    chk("reset perf", perf_stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Interlock: ADD R1 then SUB reading R1 stalls DEPTH cycles
    drv(1, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk); chk("t1 producer", hazard, 0);
    drv(1, 0, 1, 0, 2, 1, 0, 0, 0);
    @(negedge clk); chk("t1 stall a", hazard, 1); chk("t1 run a", stall_run, 0);
    drv(1, 0, 1, 0, 2, 1, 0, 0, 0);
    @(negedge clk); chk("t1 stall b", hazard, 1); chk("t1 run b", stall_run, 1);
    drv(1, 0, 1, 0, 2, 1, 0, 0, 0);
    @(negedge clk); chk("t1 release", hazard, 0); chk("t1 run c", stall_run, 2);
    idle(0);
    @(negedge clk); chk("t1 run clear", stall_run, 0); chk("t1 deadlock", deadlock_err, 0);

    // Forwarding: load-use on src2 stalls once, ALU producer never stalls
    drv(1, 0, 0, 0, 3, 1, 1, 0, 1);
    @(negedge clk); chk("t2 ldr", hazard, 0);
    drv(1, 1, 0, 3, 4, 1, 0, 0, 1);
    @(negedge clk); chk("t2 load-use", hazard, 1);
    drv(1, 1, 0, 3, 4, 1, 0, 0, 1);
    @(negedge clk); chk("t2 load-use clear", hazard, 0);
    drv(1, 0, 0, 0, 3, 1, 0, 0, 1);
    drv(1, 1, 0, 3, 4, 1, 0, 0, 1);
    @(negedge clk); chk("t2 alu no stall", hazard, 0);

    // Mode switch mid-stall takes effect in the same cycle
    drv(1, 0, 0, 0, 6, 1, 0, 0, 0);
    drv(1, 0, 6, 0, 7, 1, 0, 0, 0);
    @(negedge clk); chk("t2 interlock", hazard, 1);
    drv(1, 0, 6, 0, 7, 1, 0, 0, 1);
    @(negedge clk); chk("t2 mode switch", hazard, 0);

    // Flush beats a pending hazard and inserts a bubble
    drv(1, 0, 0, 0, 5, 1, 0, 0, 0);
    drv(1, 0, 5, 0, 8, 1, 0, 1, 0);
    @(negedge clk); chk("t3 flush", hazard, 0);
    drv(1, 0, 5, 0, 8, 1, 0, 0, 0);
    @(negedge clk); chk("t3 R5 in mem", hazard, 1);
    drv(1, 0, 5, 0, 8, 1, 0, 0, 0);
    @(negedge clk); chk("t3 R5 gone", hazard, 0);

    // src2 only counts when two_src is set
    drv(1, 0, 0, 0, 9, 1, 0, 0, 0);
    drv(1, 0, 2, 9, 10, 1, 0, 0, 0);
    @(negedge clk); chk("t4 two_src=0", hazard, 0);
    drv(1, 1, 2, 9, 10, 1, 0, 0, 0);
    @(negedge clk); chk("t4 two_src=1", hazard, 1);
    drv(1, 1, 2, 9, 10, 1, 0, 0, 0);
    idle(0);
    idle(0);
    drv(1, 0, 11, 0, 11, 1, 0, 0, 0);
    @(negedge clk); chk("t4 self src=dest", hazard, 0);

    // Async reset mid-stall
    idle(0);
    drv(1, 0, 0, 0, 1, 1, 0, 0, 0);
    drv(1, 0, 1, 0, 2, 1, 0, 0, 0);
    drv(1, 0, 1, 0, 2, 1, 0, 0, 0);
    @(negedge clk); chk("t5 pre hazard", hazard, 1); chk("t5 pre run", stall_run, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5 rst hazard", hazard, 0);
    chk("t5 rst run", stall_run, 0);
    chk("t5 rst deadlock", deadlock_err, 0);
    chk("t5 rst perf", perf_stall_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); chk("t5 tracker empty", hazard, 0);

    // 17 stall cycles from reset: 8 interlock pairs + 1 load-use
    for (int k = 0; k < 8; k++) begin
      drv(1, 0, 0, 0, 1, 1, 0, 0, 0);
      repeat (3) drv(1, 0, 1, 0, 2, 1, 0, 0, 0);
    end
    drv(1, 0, 0, 0, 3, 1, 1, 0, 1);
    drv(1, 1, 0, 3, 4, 1, 0, 0, 1);
    drv(1, 1, 0, 3, 4, 1, 0, 0, 1);
    idle(1);
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    chk("t6 perf wrap", perf_stall_cnt, 1);
`else
    chk("t6 perf tied", perf_stall_cnt, 0);
`endif
    chk("t6 deadlock", deadlock_err, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
